iomem_timer: RTL

Memory-mapped timer peripheral that answers the picosoc `iomem_*` responder interface and raises a level interrupt on compare match. It sits beside the CPU in the top-level wrapper. The CPU initiates every transfer; this block is the responder. Its `irq` output drives one of the CPU's spare interrupt lines (`irq_5`).

---
 rtl/iomem_timer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// Memory-mapped compare-match timer answering the picosoc iomem responder bus.
// One-cycle response latency; level interrupt raised on COUNT == COMPARE.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [5:0] OFF_CTRL     = 6'd0;
    localparam logic [5:0] OFF_PRESCALE = 6'd1;
    localparam logic [5:0] OFF_COMPARE  = 6'd2;
    localparam logic [5:0] OFF_COUNT    = 6'd3;
    localparam logic [5:0] OFF_STATUS   = 6'd4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_irq;
    logic                  r_en;
    logic                  r_irq_en;
    logic                  r_oneshot;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_compare;
    logic [31:0]           r_count;
    logic                  r_match;

    logic                  w_hit;
    logic                  w_accept;
    logic                  w_write;
    logic                  w_read;
    logic [5:0]            w_off;
    logic                  w_wr_ctrl;
    logic                  w_wr_prescale;
    logic                  w_wr_compare;
    logic                  w_wr_count;
    logic                  w_wr_status;
    logic                  w_tick;
    logic                  w_cmp_hit;
    logic [2:0]            w_ctrl_new;
    logic [PRESCALE_W-1:0] w_prescale_new;
    logic [31:0]           w_rd_mux;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;
    logic [31:0]           w_count_nxt;
    logic                  w_en_nxt;
    logic                  w_match_nxt;
    logic                  w_unused_addr;

    assign w_hit         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    // The ready pulse itself blocks re-acceptance of the still-held request.
    assign w_accept      = w_hit && !r_ready;
    assign w_write       = w_accept && (iomem_wstrb != 4'b0000);
    assign w_read        = w_accept && (iomem_wstrb == 4'b0000);
    assign w_off         = iomem_addr[7:2];
    assign w_unused_addr = ^iomem_addr[1:0];

    assign w_wr_ctrl     = w_write && (w_off == OFF_CTRL);
    assign w_wr_prescale = w_write && (w_off == OFF_PRESCALE);
    assign w_wr_compare  = w_write && (w_off == OFF_COMPARE);
    assign w_wr_count    = w_write && (w_off == OFF_COUNT);
    assign w_wr_status   = w_write && (w_off == OFF_STATUS);

    assign w_tick        = r_en && (r_pcnt == r_prescale);
    assign w_cmp_hit     = w_tick && (r_count == r_compare);
    assign w_ctrl_new    = iomem_wstrb[0] ? iomem_wdata[2:0] : {r_oneshot, r_irq_en, r_en};

    // Byte-strobed update of the narrow PRESCALE register
    always_comb begin
        w_prescale_new = r_prescale;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (iomem_wstrb[i/8]) begin
                w_prescale_new[i] = iomem_wdata[i];
            end else begin
                w_prescale_new[i] = r_prescale[i];
            end
        end
    end

    // Register read multiplexer; unmapped offsets read as zero
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            OFF_CTRL:     w_rd_mux = {29'd0, r_oneshot, r_irq_en, r_en};
            OFF_PRESCALE: w_rd_mux = {{(32-PRESCALE_W){1'b0}}, r_prescale};
            OFF_COMPARE:  w_rd_mux = r_compare;
            OFF_COUNT:    w_rd_mux = r_count;
            OFF_STATUS:   w_rd_mux = {31'd0, r_match};
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // Timer next state; CPU writes take priority over the counting engine
    always_comb begin
        w_pcnt_nxt  = r_pcnt;
        w_count_nxt = r_count;
        w_en_nxt    = r_en;
        w_match_nxt = r_match;

        if (w_wr_ctrl && !w_ctrl_new[0]) begin
            w_pcnt_nxt = {PRESCALE_W{1'b0}};
        end else if (w_wr_count || w_tick) begin
            w_pcnt_nxt = {PRESCALE_W{1'b0}};
        end else if (r_en) begin
            w_pcnt_nxt = r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            w_pcnt_nxt = r_pcnt;
        end

        if (w_wr_count) begin
            w_count_nxt = byte_merge(r_count, iomem_wdata, iomem_wstrb);
        end else if (w_cmp_hit) begin
            w_count_nxt = 32'd0;
        end else if (w_tick) begin
            w_count_nxt = r_count + 32'd1;
        end else begin
            w_count_nxt = r_count;
        end

        if (w_wr_ctrl) begin
            w_en_nxt = w_ctrl_new[0];
        end else if (w_cmp_hit && r_oneshot) begin
            w_en_nxt = 1'b0;
        end else begin
            w_en_nxt = r_en;
        end

        // A fresh match outranks a simultaneous write-1-clear
        if (w_cmp_hit) begin
            w_match_nxt = 1'b1;
        end else if (w_wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
            w_match_nxt = 1'b0;
        end else begin
            w_match_nxt = r_match;
        end
    end

    // Configuration and timer state registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_oneshot  <= 1'b0;
            r_prescale <= {PRESCALE_W{1'b0}};
            r_pcnt     <= {PRESCALE_W{1'b0}};
            r_compare  <= 32'hFFFF_FFFF;
            r_count    <= 32'd0;
            r_match    <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_count   <= w_count_nxt;
            r_match   <= w_match_nxt;
            if (w_wr_ctrl) begin
                r_irq_en  <= w_ctrl_new[1];
                r_oneshot <= w_ctrl_new[2];
            end
            if (w_wr_prescale) begin
                r_prescale <= w_prescale_new;
            end
            if (w_wr_compare) begin
                r_compare <= byte_merge(r_compare, iomem_wdata, iomem_wstrb);
            end
        end
    end

    // Bus response and interrupt output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_read ? w_rd_mux : 32'd0;
            r_irq   <= r_match & r_irq_en;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_irq;

endmodule
